pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
Parametrised, elastic successor to the fixed IF/ID pipeline register, for use between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload with a valid/ready handshake instead of a bare stall. It supports flush-to-bubble. An optional 2-entry skid buffer registers ready_o, cutting the combinational stall path back to the upstream stage.

Parameters:
DATA_W, 64, payload width (e.g. {PC, instruction})
SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with pass-through ready
FLUSH_VAL, {DATA_W{1'b0}}, payload presented while empty or after flush/reset (all-zero = NOP bubble)

Ports:
clk_i  in  1  clock, all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  upstream payload valid
data_i  in  DATA_W  upstream payload
ready_o  out  1  buffer can accept payload this cycle
valid_o  out  1  downstream payload valid
data_o  out  DATA_W  downstream payload
ready_i  in  1  downstream can accept
stall_i  in  1  hazard-unit stall; holds the output exactly as if ready_i = 0
flush_i  in  1  discard all held and incoming payload
count_o  out  2  occupancy 0..2 (max 1 when SKID = 0)

Behaviour:
- Definitions:
  - in_fire = valid_i & ready_o.
  - out_rdy = ready_i & ~stall_i.
  - out_fire = valid_o & out_rdy.
- State:
  - Main entry M: m_valid, m_data. It drives the output.
  - Skid entry S: s_valid, s_data. Present only when SKID = 1.
- Outputs:
  - valid_o = m_valid.
  - data_o = m_valid ? m_data : FLUSH_VAL. The payload is never stale while empty.
  - count_o = m_valid + s_valid.
- Reset:
  - While rst_i = 1 at an edge: m_valid = s_valid = 0, m_data = s_data = FLUSH_VAL.
  - After that edge: valid_o = 0, data_o = FLUSH_VAL, count_o = 0.
  - ready_o = 0 in every cycle rst_i is high; 1 in the first cycle after deassertion.
  - Reset mid-transfer drops all entries with no partial update.
- Flush, priority below reset and above everything else:
  - Next state: m_valid = s_valid = 0, data regs = FLUSH_VAL.
  - A simultaneous in_fire is accepted (upstream sees it consumed) and discarded.
  - A simultaneous out_fire still counts as delivered downstream.
- SKID = 1:
  - ready_o = ~s_valid & ~rst_i. Depends only on state and reset, never on ready_i or stall_i.
  - out_fire & s_valid: M <= S, S empties. in_fire is impossible (ready_o = 0).
  - out_fire & ~s_valid & in_fire: M <= data_i, M stays valid.
  - out_fire & ~s_valid & ~in_fire: M empties.
  - ~out_fire & in_fire & ~m_valid: M <= data_i.
  - ~out_fire & in_fire & m_valid: S <= data_i. The buffer is now full, count_o = 2, ready_o = 0 next cycle.
  - ~out_fire & ~in_fire: hold.
- SKID = 0:
  - ready_o = (out_rdy | ~m_valid) & ~rst_i. This is combinational through ready_i and stall_i.
  - in_fire: M <= data_i.
  - Else out_fire: M empties.
  - S is not instantiated; count_o[1] = 0.
- Latency and ordering:
  - One cycle from in_fire to valid_o, both modes.
  - Strict FIFO order; no payload duplicated or lost except by flush/reset.
  - Full throughput (one transfer per cycle) when out_rdy is held high.
- Stall behaviour: with stall_i = 1, data_o and valid_o hold bit-exact. In SKID mode one extra payload can be absorbed into S.
- Boundaries:
  - Full (count 2) with out_rdy high: drains S into M and reopens ready_o the following cycle.
  - Empty with out_rdy high and valid_i high: payload appears on the next cycle; no bypass in the same cycle.
  - valid_i with X data while ready_o = 0: ignored.

Decomposition:
- Shared pipeline package holds:
  - payload struct typedefs per stage boundary (if_id_t = {pc[31:0], instr[31:0]}, etc.);
  - NOP_INSTR = 32'h0000_0000;
  - FLUSH_VAL constants derived from them.
- One natural sub-module, pipe_skid_slot: a single valid+data register with load/clear/flush-value inputs. It is instantiated as M and (generate-if SKID) S.
- The control next-state logic stays in pipe_stage_buf.

Test Plan:
- Reset: assert rst_i 2 cycles with valid_i = 1, data_i = 64'hDEAD -> valid_o = 0, data_o = 0, count_o = 0, ready_o = 0 during reset and 1 the cycle after.
- Streaming: SKID = 1, ready_i = 1, feed 0x1..0x8 back-to-back -> data_o = 0x1..0x8 on cycles 1..8 after the first in_fire, ready_o constantly 1.
- Skid fill/drain: stall_i = 1 while sending 0xA, 0xB, 0xC -> 0xA held on data_o, count_o = 2, ready_o = 0, 0xC not accepted. Release stall -> outputs 0xA, 0xB, then 0xC, with ready_o back to 1 one cycle after release.
- Flush collision: count_o = 2 (0x10, 0x11), assert flush_i with in_fire of 0x12 -> next cycle valid_o = 0, data_o = FLUSH_VAL, count_o = 0, and 0x12 never appears.
- SKID = 0 comb ready: m_valid = 1, toggle ready_i 1/0 each cycle -> ready_o follows ready_i in the same cycle, count_o never exceeds 1, order preserved.
- Random: constrained-random valid_i/ready_i/stall_i/flush_i for 10k cycles against a scoreboard queue model (flush clears the queue) -> zero mismatches, count_o equals model depth every cycle.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: per-boundary payload structs, the NOP encoding,
// the bubble (flush) payloads derived from them, and a small occupancy helper.
package pipe_stage_buf_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID boundary payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // ID/EX boundary payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_t;

  // EX/MEM boundary payload.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu_res;
    logic [31:0] st_data;
  } ex_mem_t;

  // MEM/WB boundary payload.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] wb_data;
  } mem_wb_t;

  // Bubble payloads: zero PC/data with a NOP instruction.
  localparam if_id_t  IF_ID_FLUSH  = '{pc: 32'h0, instr: NOP_INSTR};
  localparam id_ex_t  ID_EX_FLUSH  = '{pc: 32'h0, instr: NOP_INSTR, rs1_val: 32'h0,
                                       rs2_val: 32'h0};
  localparam ex_mem_t EX_MEM_FLUSH = '{instr: NOP_INSTR, alu_res: 32'h0, st_data: 32'h0};
  localparam mem_wb_t MEM_WB_FLUSH = '{instr: NOP_INSTR, wb_data: 32'h0};

  // Number of occupied entries out of two.
  function automatic logic [1:0] occupancy(input logic m_valid, input logic s_valid);
    return {1'b0, m_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Single valid+data storage slot of the elastic pipeline buffer.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         capture data_i and mark the slot valid
//   clear_i        empty the slot (wins over load_i)
//   data_i         payload to capture
//   flush_val_i    payload value held while the slot is empty
//   valid_o        slot holds a payload
//   data_o         held payload (flush_val_i after reset/clear)
module pipe_skid_slot
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] flush_val_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = flush_val_i;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= flush_val_i;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register for any stage boundary, with flush to
// bubble and an optional second (skid) entry that makes ready_o a pure
// function of state, cutting the stall path back to the upstream stage.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i, data_i     upstream payload
//   ready_o             buffer accepts payload this cycle
//   valid_o, data_o     downstream payload (FLUSH_VAL while empty)
//   ready_i             downstream accepts
//   stall_i             hazard stall, behaves like ready_i = 0
//   flush_i             drop held and incoming payload
//   count_o             occupancy 0..2
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        count_o
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic              m_load, m_clear, s_load, s_clear;
  logic [DATA_W-1:0] m_din;
  logic              out_rdy, out_fire, in_fire;

  assign out_rdy  = ready_i & ~stall_i;
  assign out_fire = m_valid & out_rdy;
  assign in_fire  = valid_i & ready_o;

  // Skid mode: ready depends only on S so the upstream never sees ready_i/stall_i.
  assign ready_o = SKID ? (~s_valid & ~rst_i) : ((out_rdy | ~m_valid) & ~rst_i);

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_din   = data_i;
    if (flush_i) begin
      // Incoming payload is consumed upstream but dropped here.
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (SKID) begin
      if (out_fire) begin
        if (s_valid) begin
          m_load  = 1'b1;
          m_din   = s_data;
          s_clear = 1'b1;
        end else if (in_fire) begin
          m_load = 1'b1;
        end else begin
          m_clear = 1'b1;
        end
      end else if (in_fire) begin
        if (m_valid) begin
          s_load = 1'b1;
        end else begin
          m_load = 1'b1;
        end
      end
    end else begin
      if (in_fire) begin
        m_load = 1'b1;
      end else if (out_fire) begin
        m_clear = 1'b1;
      end
    end
  end

  pipe_skid_slot #(
    .DATA_W (DATA_W)
  ) u_m_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (m_load),
    .clear_i     (m_clear),
    .data_i      (m_din),
    .flush_val_i (FLUSH_VAL),
    .valid_o     (m_valid),
    .data_o      (m_data)
  );

  if (SKID) begin : g_skid
    pipe_skid_slot #(
      .DATA_W (DATA_W)
    ) u_s_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (s_load),
      .clear_i     (s_clear),
      .data_i      (data_i),
      .flush_val_i (FLUSH_VAL),
      .valid_o     (s_valid),
      .data_o      (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_data  = FLUSH_VAL;
  end

  assign valid_o = m_valid;
  assign data_o  = m_valid ? m_data : FLUSH_VAL;
  assign count_o = occupancy(m_valid, s_valid);

endmodule
